sram_2p_bist_ctrl: RTL
======================

SRAM_2P_BIST_CTRL -- requirements
Module: sram_2p_bist_ctrl

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 20, memory word width.
REQ-002 SHALL have parameter P_ADDR_WIDTH, default 9, memory address width; P_ADDR_COUNT = 2**P_ADDR_WIDTH words tested.
REQ-003 SHALL have port CLK, input, 1 bit: single clock, rising edge; the memory's A_BIST_CLK is tied to CLK at integration.
REQ-004 SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port START, input, 1 bit: request a test run; level-sampled.
REQ-006 SHALL have port BUSY, output, 1 bit: test in progress.
REQ-007 SHALL have port DONE, output, 1 bit: run complete; held until the next accepted START.
REQ-008 SHALL have port FAIL, output, 1 bit: sticky mismatch flag for the current or last run.
REQ-009 SHALL have port BIST_EN, output, 1 bit: drives the memory's A_BIST_EN.
REQ-010 SHALL have port BIST_ADDR, output, P_ADDR_WIDTH bits: memory address.
REQ-011 SHALL have ports BIST_DIN and BIST_BM, outputs, P_DATA_WIDTH bits each: write data and bit mask.
REQ-012 SHALL have ports BIST_MEN, BIST_WEN and BIST_REN, outputs, 1 bit each: memory enable, write enable and read enable.
REQ-013 SHALL have port BIST_DOUT, input, P_DATA_WIDTH bits: memory A_DOUT.

Function
REQ-014 SHALL execute March C- on P_ADDR_COUNT words: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
REQ-015 SHALL define D0 as all-zeros and D1 as all-ones; BIST_BM SHALL be all-ones whenever BIST_MEN is high.
REQ-016 SHALL issue one operation per cycle with no idle cycles between operations or elements; for a read-then-write pair, the read and the write to the same address SHALL occur in consecutive cycles.
REQ-017 SHALL drive all BIST_* outputs from flops.
REQ-018 SHALL define read latency as 2 cycles: an operation driven in cycle k is sampled by the memory at edge k+1, and BIST_DOUT SHALL be compared at edge k+2 against the expected value delayed through a 2-stage pipeline.
REQ-019 SHALL use BIST_REN=1 and BIST_WEN=0 for reads, and BIST_WEN=1 and BIST_REN=0 for writes.
REQ-020 SHALL use an up order of 0 to P_ADDR_COUNT-1 and a down order of P_ADDR_COUNT-1 to 0; the element SHALL advance when the address wraps past its end value.
REQ-021 SHALL implement FSM states IDLE, RUN, DRAIN and FINISH.
REQ-022 IDLE->RUN SHALL occur on START=1; this SHALL clear FAIL and DONE and load E0 at address 0.
REQ-023 RUN->DRAIN SHALL occur after the last E5 read; DRAIN SHALL last 2 cycles, during which BIST_MEN=0 and the pipeline empties.
REQ-024 DRAIN->FINISH SHALL set DONE=1 and BUSY=0.
REQ-025 FINISH->RUN SHALL occur on START=1, with the same effect as REQ-022.
REQ-026 BUSY SHALL be 1 in RUN and DRAIN; BIST_EN SHALL equal BUSY.
REQ-027 DONE SHALL rise exactly 10*P_ADDR_COUNT+2 cycles after the START-sampling edge.
REQ-028 START SHALL be ignored while BUSY=1.
REQ-029 FAIL SHALL set on any compare mismatch and SHALL remain set until the next accepted START or reset; the run SHALL continue after a failure, with no early abort.

Reset
REQ-030 RST_N low SHALL asynchronously force IDLE, and BUSY, DONE, FAIL, BIST_EN, BIST_MEN, BIST_WEN and BIST_REN to 0.
REQ-031 RST_N low SHALL asynchronously force BIST_ADDR, BIST_DIN, BIST_BM and the compare pipeline to 0.
REQ-032 Reset mid-run SHALL abort immediately, with no completion of the pending operation and no DONE.

Configuration
REQ-033 With SRAM_BIST_FAIL_CAPTURE_EN defined, the block SHALL add output FAIL_ADDR (P_ADDR_WIDTH bits) and output FAIL_ELEM (3 bits, element index 0-5).
REQ-034 With SRAM_BIST_FAIL_CAPTURE_EN defined, FAIL_ADDR and FAIL_ELEM SHALL latch the address and element of the first mismatch only.
REQ-035 With SRAM_BIST_FAIL_CAPTURE_EN defined, FAIL_ADDR and FAIL_ELEM SHALL reset to 0 and SHALL clear on an accepted START.
REQ-036 Without SRAM_BIST_FAIL_CAPTURE_EN, FAIL_ADDR, FAIL_ELEM and the capture logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-037 Package sram_bist_pkg SHALL hold the FSM state enum, the element index type and the per-element constant table (direction, read-expect value, write value, read/write flags).
REQ-038 Sub-module sram_bist_addr_gen SHALL provide an up/down loadable address counter with end-of-range flag.

Verification
REQ-039 Bench SHALL cover: P_ADDR_WIDTH=4 with a fault-free memory model and a 1-cycle START pulse -> DONE at cycle 162, FAIL=0, BUSY high for 162 cycles.
REQ-040 Bench SHALL cover: P_ADDR_WIDTH=4 with an operation trace -> w0 at addresses 0..15, then (r0,w1) at 0..15, (r1,w0) at 0..15, (r0,w1) at 15..0, (r1,w0) at 15..0, r0 at 0..15.
REQ-041 Bench SHALL cover: bit 3 stuck-at-1 at address 5 -> FAIL=1; with the macro, FAIL_ADDR=5 and FAIL_ELEM=1.
REQ-042 Bench SHALL cover: bit 0 stuck-at-0 at address 15 -> FAIL=1; with the macro, FAIL_ADDR=15 and FAIL_ELEM=2.
REQ-043 Bench SHALL cover: RST_N pulsed low during E3 -> all outputs 0 in the same cycle; a new START then passes with DONE at 162 and FAIL=0.
REQ-044 Bench SHALL cover: START held high for the whole run -> no restart while BUSY; after DONE, START with FAIL=1 set -> FAIL and DONE cleared and a new run started.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// rtl/sram_bist_pkg.sv - shared types and March C- element table for the SRAM BIST controller
package sram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    typedef logic [2:0] elem_t;

    localparam elem_t ELEM_LAST = 3'd5;

    typedef struct packed {
        logic dir_up;
        logic rd_en;
        logic rd_val;
        logic wr_en;
        logic wr_val;
    } elem_cfg_t;

    // Entries 6 and 7 are never reached; they pad the table to the index width.
    localparam elem_cfg_t ELEM_TABLE [8] = '{
        '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
        '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
        '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}
    };

endpackage

// File: rtl/sram_bist_addr_gen.sv
// rtl/sram_bist_addr_gen.sv - loadable up/down address counter with end-of-range flag
module sram_bist_addr_gen #(
    parameter int P_ADDR_WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [P_ADDR_WIDTH-1:0] load_val,
    input  logic                    step,
    input  logic                    dir_up,
    output logic [P_ADDR_WIDTH-1:0] addr,
    output logic                    at_end
);

    localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE = {{(P_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX = '1;

    logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_val;
        end else if (step) begin
            addr_d = dir_up ? (addr_q + ADDR_ONE) : (addr_q - ADDR_ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr   = addr_q;
    assign at_end = dir_up ? (addr_q == ADDR_MAX) : (addr_q == '0);

endmodule

// File: rtl/sram_2p_bist_ctrl.sv
// rtl/sram_2p_bist_ctrl.sv - March C- BIST controller for one port of a 2-port SRAM
// First-failure capture outputs FAIL_ADDR/FAIL_ELEM exist only with SRAM_BIST_FAIL_CAPTURE_EN.
module sram_2p_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int P_DATA_WIDTH = 20,
    parameter int P_ADDR_WIDTH = 9
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    START,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    FAIL,
    output logic                    BIST_EN,
    output logic [P_ADDR_WIDTH-1:0] BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] BIST_BM,
    output logic                    BIST_MEN,
    output logic                    BIST_WEN,
    output logic                    BIST_REN,
    input  logic [P_DATA_WIDTH-1:0] BIST_DOUT
`ifdef SRAM_BIST_FAIL_CAPTURE_EN
    ,
    output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
    output logic [2:0]              FAIL_ELEM
`endif
);

    localparam int P_ADDR_COUNT = 2 ** P_ADDR_WIDTH;
    localparam logic [P_ADDR_WIDTH-1:0] ADDR_LAST = P_ADDR_WIDTH'(P_ADDR_COUNT - 1);

    state_e state_q, state_d;
    elem_t  elem_q, elem_d;
    logic   phase_q, phase_d;
    logic   drain_q, drain_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   fail_q, fail_d;
    logic   men_q, men_d;
    logic   wen_q, wen_d;
    logic   ren_q, ren_d;
    logic [P_DATA_WIDTH-1:0] din_q, din_d;
    logic [P_DATA_WIDTH-1:0] bm_q, bm_d;
    logic [1:0] rd_vld_q, rd_vld_d;
    logic [1:0] rd_exp_q, rd_exp_d;

    logic start_acc;
    logic mismatch;
    logic nx_valid;
    logic nx_wr;
    logic ag_load;
    logic ag_step;
    logic ag_dir_up;
    logic ag_at_end;
    logic [P_ADDR_WIDTH-1:0] ag_load_val;
    logic [P_ADDR_WIDTH-1:0] ag_addr;

    assign start_acc = START && ((state_q == ST_IDLE) || (state_q == ST_FINISH));
    assign mismatch  = rd_vld_q[1] && (BIST_DOUT != {P_DATA_WIDTH{rd_exp_q[1]}});
    assign ag_dir_up = ELEM_TABLE[elem_q].dir_up;

    sram_bist_addr_gen #(
        .P_ADDR_WIDTH(P_ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (ag_load),
        .load_val (ag_load_val),
        .step     (ag_step),
        .dir_up   (ag_dir_up),
        .addr     (ag_addr),
        .at_end   (ag_at_end)
    );

    // elem_q/phase_q/addr describe the operation currently on the BIST_* flops;
    // the *_d values describe the one launched at the next edge.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        phase_d     = phase_q;
        drain_d     = drain_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q | mismatch;
        ag_load     = 1'b0;
        ag_load_val = '0;
        ag_step     = 1'b0;
        nx_valid    = 1'b0;

        if (start_acc) begin
            state_d  = ST_RUN;
            elem_d   = '0;
            phase_d  = 1'b0;
            ag_load  = 1'b1;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            fail_d   = 1'b0;
            nx_valid = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ELEM_TABLE[elem_q].rd_en && ELEM_TABLE[elem_q].wr_en && !phase_q) begin
                        phase_d  = 1'b1;
                        nx_valid = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (!ag_at_end) begin
                            ag_step  = 1'b1;
                            nx_valid = 1'b1;
                        end else if (elem_q == ELEM_LAST) begin
                            state_d = ST_DRAIN;
                            drain_d = 1'b0;
                        end else begin
                            elem_d      = elem_q + 3'd1;
                            ag_load     = 1'b1;
                            ag_load_val = ELEM_TABLE[elem_d].dir_up ? '0 : ADDR_LAST;
                            nx_valid    = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q) begin
                        state_d = ST_FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        drain_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        nx_wr    = phase_d | ~ELEM_TABLE[elem_d].rd_en;
        men_d    = nx_valid;
        wen_d    = nx_valid & nx_wr;
        ren_d    = nx_valid & ~nx_wr;
        din_d    = (wen_d && ELEM_TABLE[elem_d].wr_val) ? '1 : '0;
        bm_d     = nx_valid ? '1 : '0;
        rd_vld_d = {rd_vld_q[0], ren_d};
        rd_exp_d = {rd_exp_q[0], ren_d & ELEM_TABLE[elem_d].rd_val};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            elem_q   <= '0;
            phase_q  <= 1'b0;
            drain_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            men_q    <= 1'b0;
            wen_q    <= 1'b0;
            ren_q    <= 1'b0;
            din_q    <= '0;
            bm_q     <= '0;
            rd_vld_q <= '0;
            rd_exp_q <= '0;
        end else begin
            state_q  <= state_d;
            elem_q   <= elem_d;
            phase_q  <= phase_d;
            drain_q  <= drain_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            men_q    <= men_d;
            wen_q    <= wen_d;
            ren_q    <= ren_d;
            din_q    <= din_d;
            bm_q     <= bm_d;
            rd_vld_q <= rd_vld_d;
            rd_exp_q <= rd_exp_d;
        end
    end

`ifdef SRAM_BIST_FAIL_CAPTURE_EN
    logic [P_ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
    elem_t                   cap_elem_q, cap_elem_d;
    logic [P_ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    elem_t                   fail_elem_q, fail_elem_d;

    // cap_* lags the issued operation by one edge so it lines up with rd_vld_q[1].
    always_comb begin
        cap_addr_d  = ag_addr;
        cap_elem_d  = elem_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        if (start_acc) begin
            fail_addr_d = '0;
            fail_elem_d = '0;
        end else if (mismatch && !fail_q) begin
            fail_addr_d = cap_addr_q;
            fail_elem_d = cap_elem_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cap_addr_q  <= '0;
            cap_elem_q  <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else begin
            cap_addr_q  <= cap_addr_d;
            cap_elem_q  <= cap_elem_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
        end
    end

    assign FAIL_ADDR = fail_addr_q;
    assign FAIL_ELEM = fail_elem_q;
`endif

    assign BUSY      = busy_q;
    assign BIST_EN   = busy_q;
    assign DONE      = done_q;
    assign FAIL      = fail_q;
    assign BIST_ADDR = ag_addr;
    assign BIST_DIN  = din_q;
    assign BIST_BM   = bm_q;
    assign BIST_MEN  = men_q;
    assign BIST_WEN  = wen_q;
    assign BIST_REN  = ren_q;

endmodule
